// File: rtl/clk_tick_gen.sv
// ============================================================================
// clk_tick_gen
// ----------------------------------------------------------------------------
// Multi-channel programmable tick generator. Provides a free-running cycle
// counter plus CHANNELS independent divide-by-N channels. Each channel emits
// a one-cycle tick strobe and (optionally) a square wave that toggles on each
// tick. Divisors can be rewritten at run time. A running channel only adopts
// a new divisor at the end of its current period, so periods are never cut
// short or stretched.
//
// Optional feature macro: CLK_TICK_SQUARE_EN
//   defined   : sq[] toggles on every tick of its channel
//   undefined : no square-wave flops, sq[] is constant 0
//
// Parameters:
//   CHANNELS    number of divider channels (2..16)
//   DIV_W       width of each channel divisor / counter
//   CNT_W       width of the free-running counter
//   DEFAULT_DIV divisor loaded into every channel at reset
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   en        in   global channel enable (does not gate free_cnt)
//   cfg_we    in   divisor write strobe
//   cfg_ch    in   target channel index
//   cfg_div   in   new divisor, 0 idles the channel
//   cfg_ack   out  pulse one cycle after an accepted write
//   cfg_err   out  pulse one cycle after a write to a nonexistent channel
//   free_cnt  out  free-running cycle count
//   tick      out  per-channel one-cycle strobe
//   sq        out  per-channel square wave
// ============================================================================
module clk_tick_gen #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DIV_W       = 24,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    output logic                        cfg_ack,
    output logic                        cfg_err,
    output logic [CNT_W-1:0]            free_cnt,
    output logic [CHANNELS-1:0]         tick,
    output logic [CHANNELS-1:0]         sq
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

    logic [CNT_W-1:0]                 free_cnt_q;
    logic [CHANNELS-1:0][DIV_W-1:0]   cnt_q, cnt_d;
    logic [CHANNELS-1:0][DIV_W-1:0]   active_q, active_d;
    logic [CHANNELS-1:0][DIV_W-1:0]   pending_q, pending_d;
    logic [CHANNELS-1:0]              tick_q, tick_d;
    logic                             cfg_ack_q, cfg_err_q;

    logic [31:0]                      cfg_ch_ext;
    logic                             cfg_valid;
    logic [CHANNELS-1:0]              cfg_hit;
    logic [CHANNELS-1:0]              term;

    // Zero-extend the index so a non-power-of-two CHANNELS can be range
    // checked without a constant-result comparison.
    assign cfg_ch_ext = 32'(cfg_ch);
    assign cfg_valid  = (cfg_ch_ext < CHANNELS);

    always_comb begin
        cfg_hit = '0;
        term    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch_ext == i);
            term[i]    = en && (active_q[i] != '0)
                         && (cnt_q[i] == active_q[i] - DIV_W'(1));
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        active_d  = active_q;
        pending_d = pending_q;
        tick_d    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (en && (active_q[i] != '0)) begin
                if (term[i]) begin
                    cnt_d[i]    = '0;
                    tick_d[i]   = 1'b1;
                    active_d[i] = pending_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                end
            end
            if (cfg_hit[i]) begin
                pending_d[i] = cfg_div;
                // Idle channels start right away; a write landing on the
                // terminal count overrides the pending value just adopted.
                if (active_q[i] == '0) begin
                    active_d[i] = cfg_div;
                    cnt_d[i]    = '0;
                end else if (term[i]) begin
                    active_d[i] = cfg_div;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_cnt_q <= '0;
            cnt_q      <= '0;
            active_q   <= {CHANNELS{DEF_DIV}};
            pending_q  <= {CHANNELS{DEF_DIV}};
            tick_q     <= '0;
            cfg_ack_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            free_cnt_q <= free_cnt_q + CNT_W'(1);
            cnt_q      <= cnt_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            tick_q     <= tick_d;
            cfg_ack_q  <= cfg_we && cfg_valid;
            cfg_err_q  <= cfg_we && !cfg_valid;
        end
    end

`ifdef CLK_TICK_SQUARE_EN
    logic [CHANNELS-1:0] sq_q, sq_d;

    always_comb begin
        sq_d = sq_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (tick_d[i]) begin
                sq_d[i] = ~sq_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`else
    assign sq = '0;
`endif

    assign free_cnt = free_cnt_q;
    assign tick     = tick_q;
    assign cfg_ack  = cfg_ack_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// ============================================================================
// tb_clk_tick_gen
// ----------------------------------------------------------------------------
// Directed bench for clk_tick_gen with three channels (so index 3 is out of
// range). The driver pushes hand-computed tick / ack / err cycle numbers into
// queues as it issues stimulus; a negedge monitor pops and compares whenever
// the DUT raises an output or an event is due. Cycle numbers count rising
// edges since the last reset release.
// ============================================================================
module tb_clk_tick_gen;

    localparam int NCH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [23:0] cfg_div = '0;
    logic        cfg_ack, cfg_err;
    logic [31:0] free_cnt;
    logic [NCH-1:0] tick, sq;

    clk_tick_gen #(
        .CHANNELS    (NCH),
        .DIV_W       (24),
        .CNT_W       (32),
        .DEFAULT_DIV (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_ack  (cfg_ack),
        .cfg_err  (cfg_err),
        .free_cnt (free_cnt),
        .tick     (tick),
        .sq       (sq)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_on = 1'b0;

    int unsigned    exp_tick [NCH][$];
    int unsigned    exp_ack [$];
    int unsigned    exp_err [$];
    logic [NCH-1:0] sq_model = '0;

    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_on) begin
            bit e;
            for (int c = 0; c < NCH; c++) begin
                e = (exp_tick[c].size() > 0) && (exp_tick[c][0] == cyc);
                if (e) begin
                    void'(exp_tick[c].pop_front());
`ifdef CLK_TICK_SQUARE_EN
                    sq_model[c] = ~sq_model[c];
`endif
                end
                if (e || tick[c]) check($sformatf("tick%0d", c), 64'(tick[c]), 64'(e));
            end
            check("sq", 64'(sq), 64'(sq_model));
            e = (exp_ack.size() > 0) && (exp_ack[0] == cyc);
            if (e) void'(exp_ack.pop_front());
            if (e || cfg_ack) check("cfg_ack", 64'(cfg_ack), 64'(e));
            e = (exp_err.size() > 0) && (exp_err[0] == cyc);
            if (e) void'(exp_err.pop_front());
            if (e || cfg_err) check("cfg_err", 64'(cfg_err), 64'(e));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ticks(input int c, input int unsigned first, input int unsigned period,
                              input int unsigned last);
        for (int unsigned k = first; k <= last; k += period) exp_tick[c].push_back(k);
    endtask

    // Drop expected ticks later than keep_upto (channel behaviour changes).
    task automatic trim(input int c, input int unsigned keep_upto);
        while (exp_tick[c].size() > 0 && exp_tick[c][exp_tick[c].size()-1] > keep_upto)
            void'(exp_tick[c].pop_back());
    endtask

    task automatic write(input logic [1:0] ch, input logic [23:0] div);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = div;
        if (int'(ch) < NCH) exp_ack.push_back(cyc + 1);
        else                exp_err.push_back(cyc + 1);
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_free_cnt"}, 64'(free_cnt), 64'd0);
        check({tag, "_tick"},     64'(tick),     64'd0);
        check({tag, "_sq"},       64'(sq),       64'd0);
        check({tag, "_cfg_ack"},  64'(cfg_ack),  64'd0);
        check({tag, "_cfg_err"},  64'(cfg_err),  64'd0);
    endtask

    initial begin
        // Reset with en high and a write presented: the write must vanish.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 24'd7;
        step(3);
        check_all_zero("reset");
        mon_on = 1'b1;
        rst = 1'b0; cfg_we = 1'b0;
        for (int c = 0; c < NCH; c++) push_ticks(c, 2, 2, 86);

        step(20);                                   // cycle 20
        check("free_cnt_20", 64'(free_cnt), 64'd20);

        // ch1 -> 5 while its cnt is 0: one more 2-cycle period, then every 5.
        trim(1, 22); push_ticks(1, 27, 5, 86);
        write(2'd1, 24'd5);                         // cycle 21
        step(1);                                    // cycle 22
        // ch2 -> 0: finishes period ending at 24, then idles.
        trim(2, 24);
        write(2'd2, 24'd0);                         // cycle 23
        step(7);                                    // cycle 30
        // ch0 -> 4
        trim(0, 32); push_ticks(0, 36, 4, 86);
        write(2'd0, 24'd4);                         // cycle 31
        step(9);                                    // cycle 40
        // ch2 idle -> 3: loads at edge 41, first tick at 44.
        push_ticks(2, 44, 3, 86);
        write(2'd2, 24'd3);                         // cycle 41
        step(4);                                    // cycle 45
        check("free_cnt_45", 64'(free_cnt), 64'd45);

        // en low for edges 46..52: every pending tick shifts by 7.
        en = 1'b0;
        trim(0, 44); push_ticks(0, 55, 4, 86);
        trim(1, 42); push_ticks(1, 54, 5, 86);
        trim(2, 44); push_ticks(2, 54, 3, 86);
        step(7);                                    // cycle 52
        check("free_cnt_52", 64'(free_cnt), 64'd52);
        en = 1'b1;
        step(8);                                    // cycle 60

        // Back-to-back: out-of-range, then three accepted writes.
        write(2'd3, 24'd9);                         // err at 61
        write(2'd2, 24'd3);                         // ack at 62
        write(2'd0, 24'd4);                         // ack at 63
        // ch1 write lands on its terminal edge 64: new div 3 applies at once.
        trim(1, 64); push_ticks(1, 67, 3, 86);
        write(2'd1, 24'd3);                         // cycle 64, ack at 64
        step(16);                                   // cycle 80

        // Free counter wrap.
        force dut.free_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.free_cnt_q;
        step(1);                                    // cycle 81
        check("free_cnt_max", 64'(free_cnt), 64'h0000_0000_FFFF_FFFF);
        step(1);                                    // cycle 82
        check("free_cnt_wrap", 64'(free_cnt), 64'd0);
        step(4);                                    // cycle 86

        // Reset mid-run (ch0 and ch2 would tick at 87) with a write presented.
        rst = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 24'd7;
        step(1);                                    // cycle 0
        for (int c = 0; c < NCH; c++) exp_tick[c].delete();
        sq_model = '0;
        check_all_zero("midreset");
        rst = 1'b0; cfg_we = 1'b0;
        for (int c = 0; c < NCH; c++) push_ticks(c, 2, 2, 12);
        step(12);
        @(negedge clk);
        #1;
        check("ack_queue_drained", 64'(exp_ack.size()), 64'd0);
        check("err_queue_drained", 64'(exp_err.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
